mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal 32 or 64.
REQ-002 Parameter UNROLL, default 1: multiplier bits retired per CALC cycle; legal 1, 2, 4, 8; N = XLEN/UNROLL.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start_i  in  1  request; accepted when start_i && ready_o && !kill_i.
REQ-006 func3_i  in  3  RV M opcode; bits [1:0] decoded: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 ignored.
REQ-007 op1_i / op2_i  in  XLEN each  rs1 / rs2 operands, sampled at accept only.
REQ-008 kill_i  in  1  pipeline flush; aborts an in-flight op.
REQ-009 ready_o  out  1  high in IDLE and DONE.
REQ-010 busy_o  out  1  high in CALC.
REQ-011 valid_o  out  1  one-cycle result strobe, high in DONE only.
REQ-012 result_o  out  XLEN  result; holds last value until the next DONE.

Function
REQ-013 States IDLE, CALC, DONE; reset to IDLE.
REQ-014 Signedness: MUL/MULHU unsigned x unsigned; MULH signed x signed; MULHSU signed op1 x unsigned op2.
REQ-015 Product is the exact 2*XLEN-bit two's-complement product; MUL returns bits [XLEN-1:0], others return bits [2XLEN-1:XLEN].
REQ-016 Datapath: operand magnitudes multiplied unsigned by iterative shift-add, UNROLL bits/cycle; the 2XLEN result is negated at the CALC->DONE edge when exactly one signed operand is negative.
REQ-017 Accept at edge E0 (miss): IDLE/DONE->CALC; after N CALC cycles, ->DONE at edge E0+N; valid_o high for the cycle E0+N..E0+N+1.
REQ-018 DONE->IDLE on the next edge unless a new start is accepted, which takes CALC (or DONE on hit) directly; back-to-back ops have no bubble.
REQ-019 Operand cache: on each completed op, store op1, op2, signedness mode, full 2XLEN product; set cache_vld.
REQ-020 Cache hit: cache_vld && op1/op2 equal && (mode equal || new op is MUL); on hit, accept goes straight to DONE, valid_o one cycle after E0.
REQ-021 MUL hits regardless of stored mode (low half is signedness-independent).
REQ-022 kill_i in CALC: ->IDLE next edge, no valid_o, result_o and cache unchanged.
REQ-023 kill_i with start_i in the same cycle: kill wins, start not accepted.
REQ-024 kill_i in DONE: valid_o still asserted that cycle; start blocked.
REQ-025 start_i while in CALC is ignored (ready_o = 0); no queuing.
REQ-026 Operand inputs may change after accept without affecting the op.

Reset
REQ-027 rst at an edge: state IDLE, valid_o 0, busy_o 0, result_o 0, cache_vld 0, iteration counter 0.
REQ-028 rst wins over start_i and kill_i; reset mid-CALC abandons the op with no valid_o.
REQ-029 ready_o is high in the first cycle after reset release.

Verification (XLEN=32, UNROLL=1 unless stated)
REQ-030 MUL 0x00000007 x 0xFFFFFFFD -> valid_o exactly 32 cycles after accept, result 0xFFFFFFEB.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU same operands -> 0xFFFFFFFF; MULH same operands -> 0x00000000; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-032 After MULHU 0xFFFFFFFF x 0xFFFFFFFF completes, MUL same operands -> valid_o 1 cycle after accept, result 0x00000001; MULH same operands -> full 32-cycle latency (mode miss).
REQ-033 Start MUL 3 x 5, kill_i at cycle 10 -> no valid_o, ready_o high next cycle, result_o unchanged; restart same op -> 32-cycle latency, result 0x0000000F.
REQ-034 rst asserted mid-CALC at cycle 5 -> next cycle busy_o 0, valid_o 0, result_o 0; following MUL 2 x 3 -> 32-cycle latency (cache cleared), result 0x00000006.
REQ-035 UNROLL=4: MUL 0x12345678 x 0x00000010 -> valid_o 8 cycles after accept, result 0x23456780; start held during DONE -> next op accepted with no idle cycle.

Source files
------------

// File: rtl/mul_iter_if.sv
// Request/response bundle for the iterative RV M-extension multiplier.
interface mul_iter_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            kill_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  // Issuing side (pipeline / testbench)
  modport master (
    output start_i, func3_i, op1_i, op2_i, kill_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  // Multiplier side
  modport slave (
    input  start_i, func3_i, op1_i, op2_i, kill_i,
    output ready_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU with a one-entry
// operand cache. Magnitudes are multiplied unsigned, UNROLL multiplier bits
// per cycle; the sign is applied once when the product leaves CALC.
module mul_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic   clk,
  input  logic   rst,
  mul_iter_if.slave bus
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // mode = {op1 signed, op2 signed}
  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [1:0]      mode;
    logic [PW-1:0]   prod;
  } cache_t;

  state_t          state_q, state_d;
  logic            ready, busy, valid;

  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q, mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic            neg_q;
  logic [1:0]      fn_q, mode_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [XLEN-1:0] result_q;

  cache_t          cache_q;
  logic            cache_vld_q;

  // Request decode
  logic [1:0]      fn, mode;
  logic            s1, s2, neg, hit, accept, last;
  logic [XLEN-1:0] mag1, mag2;

  assign fn     = bus.func3_i[1:0];
  assign s1     = (fn == 2'b01) || (fn == 2'b10);
  assign s2     = (fn == 2'b01);
  assign mode   = {s1, s2};
  assign neg    = (s1 & bus.op1_i[XLEN-1]) ^ (s2 & bus.op2_i[XLEN-1]);
  assign mag1   = (s1 && bus.op1_i[XLEN-1]) ? -bus.op1_i : bus.op1_i;
  assign mag2   = (s2 && bus.op2_i[XLEN-1]) ? -bus.op2_i : bus.op2_i;
  // Low half of a product is identical for every signedness, so MUL may
  // reuse an entry stored under any mode.
  assign hit    = cache_vld_q && (bus.op1_i == cache_q.op1) && (bus.op2_i == cache_q.op2)
                  && ((mode == cache_q.mode) || (fn == 2'b00));
  assign accept = bus.start_i && ready && !bus.kill_i;
  assign last   = (cnt_q == CW'(N - 1));

  // Partial products for the UNROLL multiplier bits retired this cycle
  logic [PW-1:0] pp [UNROLL];
  logic [PW-1:0] acc_nxt, prod_fin;

  genvar k;
  generate
    for (k = 0; k < UNROLL; k++) begin : g_pp
      assign pp[k] = mplier_q[k] ? (mcand_q << k) : '0;
    end
  endgenerate

  // Accumulate this cycle's partial products
  always_comb begin
    acc_nxt = acc_q;
    for (int i = 0; i < UNROLL; i++) acc_nxt = acc_nxt + pp[i];
  end

  assign prod_fin = neg_q ? -acc_nxt : acc_nxt;

  function automatic logic [XLEN-1:0] sel_half(input logic [PW-1:0] p, input logic [1:0] f);
    return (f == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: kill only aborts CALC; in DONE it merely blocks a new accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)               state_d = hit ? DONE : CALC;
        else                      state_d = IDLE;
      end
      CALC: begin
        if (bus.kill_i)           state_d = IDLE;
        else if (last)            state_d = DONE;
      end
      default:                    state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    valid = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      CALC:    busy  = 1'b1;
      DONE:    begin ready = 1'b1; valid = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  assign bus.ready_o  = ready;
  assign bus.busy_o   = busy;
  assign bus.valid_o  = valid;
  assign bus.result_o = result_q;

  // Datapath: capture on accept, shift-add in CALC, commit result/cache at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      fn_q        <= '0;
      mode_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      result_q    <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mag1};
      mplier_q <= mag2;
      neg_q    <= neg;
      fn_q     <= fn;
      mode_q   <= mode;
      op1_q    <= bus.op1_i;
      op2_q    <= bus.op2_i;
      if (hit) result_q <= sel_half(cache_q.prod, fn);
    end else if (state_q == CALC) begin
      if (bus.kill_i || last) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (!bus.kill_i) begin
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_q << UNROLL;
        mplier_q <= mplier_q >> UNROLL;
        if (last) begin
          result_q    <= sel_half(prod_fin, fn_q);
          cache_q     <= '{op1: op1_q, op2: op2_q, mode: mode_q, prod: prod_fin};
          cache_vld_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mul_iter.sv
// Directed bench: UNROLL=1 instance for functional/cache/kill/reset cases,
// UNROLL=4 instance for latency and back-to-back issue.
module tb_mul_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  mul_iter_if #(.XLEN(32)) b1 ();
  mul_iter_if #(.XLEN(32)) b4 ();

  mul_iter #(.XLEN(32), .UNROLL(1)) dut  (.clk(clk), .rst(rst), .bus(b1.slave));
  mul_iter #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the UNROLL=1 instance. Latency = clock edges from the
  // accept edge to the edge entering DONE (hit -> 0, miss -> 32).
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    @(negedge clk);
    chk({tag, "_ready"}, b1.ready_o, 1);
    b1.start_i = 1'b1; b1.func3_i = f; b1.op1_i = a; b1.op2_i = b;
    @(posedge clk); #1;
    b1.start_i = 1'b0; b1.func3_i = f ^ 3'b011; b1.op1_i = ~a; b1.op2_i = ~b;
    lat = 0;
    while (!b1.valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, b1.result_o, exp_res);
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, b1.valid_o, 0);
    chk({tag, "_hold"}, b1.result_o, exp_res);
  endtask

  initial begin
    b1.start_i = 0; b1.func3_i = 0; b1.op1_i = 0; b1.op2_i = 0; b1.kill_i = 0;
    b4.start_i = 0; b4.func3_i = 0; b4.op1_i = 0; b4.op2_i = 0; b4.kill_i = 0;

    // Reset, with start/kill asserted to show reset wins
    b1.start_i = 1; b1.kill_i = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0; b1.start_i = 0; b1.kill_i = 0;
    chk("rst_ready", b1.ready_o, 1);
    chk("rst_busy",  b1.busy_o, 0);
    chk("rst_valid", b1.valid_o, 0);
    chk("rst_result", b1.result_o, 0);
    chk("rst4_ready", b4.ready_o, 1);

    // Main function
    run_op("mul_neg",  3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32, 32'hFFFF_FFEB);
    run_op("mul_hit_f3b2", 3'b100, 32'h0000_0007, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE);
    run_op("mul_hit",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  32'h0000_0001);
    run_op("mulh_miss",3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0000);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFF);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000);

    // Kill mid-CALC at cycle 10
    @(negedge clk);
    b1.start_i = 1; b1.func3_i = 0; b1.op1_i = 3; b1.op2_i = 5;
    @(posedge clk); #1; b1.start_i = 0;
    chk("kill_busy_pre", b1.busy_o, 1);
    repeat (9) @(posedge clk);
    #1 b1.kill_i = 1;
    @(posedge clk); #1; b1.kill_i = 0;
    chk("kill_ready", b1.ready_o, 1);
    chk("kill_busy",  b1.busy_o, 0);
    chk("kill_valid", b1.valid_o, 0);
    chk("kill_res",   b1.result_o, 32'h4000_0000);
    run_op("kill_redo", 3'b000, 32'h3, 32'h5, 32, 32'h0000_000F);

    // Kill and start together: start not accepted
    @(negedge clk);
    b1.start_i = 1; b1.kill_i = 1; b1.op1_i = 9; b1.op2_i = 9;
    @(posedge clk); #1; b1.start_i = 0; b1.kill_i = 0;
    chk("killstart_busy", b1.busy_o, 0);
    chk("killstart_ready", b1.ready_o, 1);

    // Reset mid-CALC must also drop the cache entry
    run_op("pre_rst", 3'b000, 32'h2, 32'h3, 32, 32'h0000_0006);
    @(negedge clk);
    b1.start_i = 1; b1.func3_i = 0; b1.op1_i = 4; b1.op2_i = 5;
    @(posedge clk); #1; b1.start_i = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("midrst_busy",  b1.busy_o, 0);
    chk("midrst_valid", b1.valid_o, 0);
    chk("midrst_res",   b1.result_o, 0);
    chk("midrst_ready", b1.ready_o, 1);
    run_op("post_rst", 3'b000, 32'h2, 32'h3, 32, 32'h0000_0006);

    // UNROLL=4: 8-cycle latency, start held through DONE issues without a bubble
    @(negedge clk);
    b4.start_i = 1; b4.func3_i = 0; b4.op1_i = 32'h1234_5678; b4.op2_i = 32'h10;
    @(posedge clk); #1;
    b4.op1_i = 32'h3; b4.op2_i = 32'h100;
    lat = 0;
    while (!b4.valid_o && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("u4_lat", lat, 8);
    chk("u4_res", b4.result_o, 32'h2345_6780);
    @(posedge clk); #1; b4.start_i = 0;
    chk("u4_b2b_busy",  b4.busy_o, 1);
    chk("u4_b2b_valid", b4.valid_o, 0);
    lat = 0;
    while (!b4.valid_o && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("u4_b2b_lat", lat, 8);
    chk("u4_b2b_res", b4.result_o, 32'h0000_0300);

    // Kill in DONE: strobe survives, concurrent start is blocked
    b4.kill_i = 1; b4.start_i = 1; b4.op1_i = 32'h7; b4.op2_i = 32'h7;
    #1 chk("u4_kdone_valid", b4.valid_o, 1);
    @(posedge clk); #1; b4.kill_i = 0; b4.start_i = 0;
    chk("u4_kdone_busy",  b4.busy_o, 0);
    chk("u4_kdone_ready", b4.ready_o, 1);
    chk("u4_kdone_valid2", b4.valid_o, 0);
    chk("u4_kdone_res",   b4.result_o, 32'h0000_0300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
